// File: rtl/rv32_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32_decode_stage: RV32I/Zicsr decoder feeding a skid FIFO, multi-hart tag |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rv32_decode_stage #(
  parameter int XPR_LEN        = 32,
  parameter int HART_CNT_WIDTH = 3,
  parameter int SKID_DEPTH     = 2,
  parameter int EN_CSR         = 1,
  parameter int ILL_CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XPR_LEN-1:0]        in_instr,
  input  logic [XPR_LEN-1:0]        in_pc,
  input  logic [HART_CNT_WIDTH-1:0] in_hart,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5:0]                out_opcode,
  output logic [XPR_LEN-1:0]        out_imm,
  output logic [11:0]               out_csr,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic [4:0]                out_rd,
  output logic [5:0]                out_type,
  output logic                      out_illegal,
  output logic [XPR_LEN-1:0]        out_pc,
  output logic [HART_CNT_WIDTH-1:0] out_hart,
  output logic [ILL_CNT_WIDTH-1:0]  ill_cnt
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [5:0] T_R = 6'h20, T_I = 6'h10, T_S = 6'h08, T_B = 6'h04;
  localparam logic [5:0] T_U = 6'h02, T_J = 6'h01, T_NONE = 6'h00, T_UNK = 6'h3F;

  localparam logic [5:0] LB = 6'h00, LH = 6'h01, LW = 6'h02, LBU = 6'h03, LHU = 6'h04;
  localparam logic [5:0] SB = 6'h05, SH = 6'h06, SW = 6'h07;
  localparam logic [5:0] SLL = 6'h08, SLLI = 6'h09, SRL = 6'h0A, SRLI = 6'h0B;
  localparam logic [5:0] SRA = 6'h0C, SRAI = 6'h0D, ADD = 6'h0E, ADDI = 6'h0F;
  localparam logic [5:0] SUB = 6'h10, LUI = 6'h11, AUIPC = 6'h12, XOR_ = 6'h13;
  localparam logic [5:0] XORI = 6'h14, OR_ = 6'h15, ORI = 6'h16, AND_ = 6'h17;
  localparam logic [5:0] ANDI = 6'h18, SLT = 6'h19, SLTI = 6'h1A, SLTU = 6'h1B;
  localparam logic [5:0] SLTIU = 6'h1C, BEQ = 6'h1D, BNE = 6'h1E, BLT = 6'h1F;
  localparam logic [5:0] BGE = 6'h20, BLTU = 6'h21, BGEU = 6'h22, JAL = 6'h23;
  localparam logic [5:0] JALR = 6'h24, FENCE = 6'h25, FENCEI = 6'h26;
  localparam logic [5:0] CSRRW = 6'h27, CSRRS = 6'h28, CSRRC = 6'h29;
  localparam logic [5:0] CSRRWI = 6'h2A, CSRRSI = 6'h2B, CSRRCI = 6'h2C;
  localparam logic [5:0] ECALL = 6'h2D, EBREAK = 6'h2E, ERET = 6'h2F, WFI = 6'h30;
  localparam logic [5:0] MRET = 6'h31, NOP = 6'h32, UNKNOWN = 6'h3F;

  typedef struct packed {
    logic [5:0]                opcode;
    logic [XPR_LEN-1:0]        imm;
    logic [11:0]               csr;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [4:0]                rd;
    logic [5:0]                typ;
    logic                      illegal;
    logic [XPR_LEN-1:0]        pc;
    logic [HART_CNT_WIDTH-1:0] hart;
  } entry_t;

  // ---------------------------------------------------------------- decode
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [XPR_LEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_z;
  logic               ok;
  logic [5:0]         d_op, d_type;
  logic [XPR_LEN-1:0] d_imm;
  entry_t             dec;

  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm_i  = {{(XPR_LEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XPR_LEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XPR_LEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{(XPR_LEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  assign imm_sh = {{(XPR_LEN-5){1'b0}}, in_instr[24:20]};
  assign imm_z  = {{(XPR_LEN-5){1'b0}}, in_instr[19:15]};

  always_comb begin
    ok     = 1'b1;
    d_op   = UNKNOWN;
    d_type = T_I;
    d_imm  = imm_i;
    case (in_instr[6:0])
      OPC_LOAD: begin
        case (f3)
          3'd0: d_op = LB;
          3'd1: d_op = LH;
          3'd2: d_op = LW;
          3'd4: d_op = LBU;
          3'd5: d_op = LHU;
          default: ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        d_type = T_S;
        d_imm  = imm_s;
        case (f3)
          3'd0: d_op = SB;
          3'd1: d_op = SH;
          3'd2: d_op = SW;
          default: ok = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        case (f3)
          3'd0: d_op = ADDI;
          3'd1: begin d_op = SLLI; d_imm = imm_sh; ok = (f7 == 7'h00); end
          3'd2: d_op = SLTI;
          3'd3: d_op = SLTIU;
          3'd4: d_op = XORI;
          3'd5: begin
            d_imm = imm_sh;
            d_op  = (f7 == 7'h20) ? SRAI : SRLI;
            ok    = (f7 == 7'h00) || (f7 == 7'h20);
          end
          3'd6: d_op = ORI;
          default: d_op = ANDI;
        endcase
      end
      OPC_OP: begin
        d_type = T_R;
        d_imm  = '0;
        case ({f7, f3})
          {7'h00, 3'd0}: d_op = ADD;
          {7'h20, 3'd0}: d_op = SUB;
          {7'h00, 3'd1}: d_op = SLL;
          {7'h00, 3'd2}: d_op = SLT;
          {7'h00, 3'd3}: d_op = SLTU;
          {7'h00, 3'd4}: d_op = XOR_;
          {7'h00, 3'd5}: d_op = SRL;
          {7'h20, 3'd5}: d_op = SRA;
          {7'h00, 3'd6}: d_op = OR_;
          {7'h00, 3'd7}: d_op = AND_;
          default: ok = 1'b0;
        endcase
      end
      OPC_LUI:   begin d_op = LUI;   d_type = T_U; d_imm = imm_u; end
      OPC_AUIPC: begin d_op = AUIPC; d_type = T_U; d_imm = imm_u; end
      OPC_JAL:   begin d_op = JAL;   d_type = T_J; d_imm = imm_j; end
      OPC_JALR:  begin d_op = JALR;  ok = (f3 == 3'd0); end
      OPC_BRANCH: begin
        d_type = T_B;
        d_imm  = imm_b;
        case (f3)
          3'd0: d_op = BEQ;
          3'd1: d_op = BNE;
          3'd4: d_op = BLT;
          3'd5: d_op = BGE;
          3'd6: d_op = BLTU;
          3'd7: d_op = BGEU;
          default: ok = 1'b0;
        endcase
      end
      OPC_MISC: begin
        case (f3)
          3'd0: d_op = FENCE;
          3'd1: d_op = FENCEI;
          default: ok = 1'b0;
        endcase
      end
      OPC_SYSTEM: begin
        if (f3 == 3'd0) begin
          // Privileged ops are matched on the whole word, not just funct12.
          case (in_instr[31:0])
            32'h00000073: d_op = ECALL;
            32'h00100073: d_op = EBREAK;
            32'h10200073: d_op = ERET;
            32'h10500073: d_op = WFI;
            32'h30200073: d_op = MRET;
            default: ok = 1'b0;
          endcase
        end else if (EN_CSR != 0) begin
          case (f3)
            3'd1: d_op = CSRRW;
            3'd2: d_op = CSRRS;
            3'd3: d_op = CSRRC;
            3'd5: begin d_op = CSRRWI; d_imm = imm_z; end
            3'd6: begin d_op = CSRRSI; d_imm = imm_z; end
            3'd7: begin d_op = CSRRCI; d_imm = imm_z; end
            default: ok = 1'b0;
          endcase
        end else begin
          ok = 1'b0;
        end
      end
      default: ok = 1'b0;
    endcase

    if (in_instr == '0) begin
      ok     = 1'b1;
      d_op   = NOP;
      d_type = T_NONE;
      d_imm  = '0;
    end else if (!ok) begin
      d_op   = UNKNOWN;
      d_type = T_UNK;
      d_imm  = '0;
    end

    dec         = '0;
    dec.opcode  = d_op;
    dec.imm     = d_imm;
    dec.csr     = in_instr[31:20];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    dec.typ     = d_type;
    dec.illegal = !ok;
    dec.pc      = in_pc;
    dec.hart    = in_hart;
  end

  // ---------------------------------------------------------------- skid FIFO
  localparam int AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(SKID_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(SKID_DEPTH - 1);

  entry_t        mem [SKID_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  entry_t        head;

  assign in_ready  = (count != DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ill_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (dec.illegal && (ill_cnt != '1)) ill_cnt <= ill_cnt + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_opcode  = head.opcode;
  assign out_imm     = head.imm;
  assign out_csr     = head.csr;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_type    = head.typ;
  assign out_illegal = head.illegal;
  assign out_pc      = head.pc;
  assign out_hart    = head.hart;

endmodule
`default_nettype wire

// File: tb/tb_rv32_decode_stage.sv
`default_nettype none
// Directed bench for rv32_decode_stage: default instance plus a CSR-disabled,
// 4-bit-counter instance for the saturation and EN_CSR=0 cases.
module tb_rv32_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [2:0]  in_hart, out_hart;
  logic [5:0]  out_opcode, out_type;
  logic [11:0] out_csr;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [15:0] ill_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr, b_out_imm, b_out_pc;
  logic [2:0]  b_out_hart;
  logic [5:0]  b_out_opcode, b_out_type;
  logic [11:0] b_out_csr;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
  logic [3:0]  b_ill_cnt;

  rv32_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_hart(in_hart), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_imm(out_imm), .out_csr(out_csr), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_type(out_type), .out_illegal(out_illegal),
    .out_pc(out_pc), .out_hart(out_hart), .ill_cnt(ill_cnt)
  );

  rv32_decode_stage #(.EN_CSR(0), .ILL_CNT_WIDTH(4)) dut_nocsr (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(32'h0000_0400), .in_hart(3'd1), .flush(1'b0),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_opcode(b_out_opcode),
    .out_imm(b_out_imm), .out_csr(b_out_csr), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_rd(b_out_rd), .out_type(b_out_type), .out_illegal(b_out_illegal),
    .out_pc(b_out_pc), .out_hart(b_out_hart), .ill_cnt(b_ill_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] p, input logic [2:0] h);
    in_valid = 1'b1; in_instr = ins; in_pc = p; in_hart = h;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] ins);
    b_in_valid = 1'b1; b_in_instr = ins;
    tick();
    b_in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_hart = '0;
    flush = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_instr = '0; b_out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_ill_cnt", ill_cnt, 0);
    check_eq("rst_opcode", out_opcode, 0);
    check_eq("rst_imm", out_imm, 0);

    // addi x5,x0,-1
    send(32'hFFF00293, 32'h100, 3'd3);
    check_eq("addi_valid", out_valid, 1);
    check_eq("addi_op", out_opcode, 6'h0F);
    check_eq("addi_imm", out_imm, 32'hFFFFFFFF);
    check_eq("addi_rd", out_rd, 5);
    check_eq("addi_rs1", out_rs1, 0);
    check_eq("addi_type", out_type, 6'h10);
    check_eq("addi_pc", out_pc, 32'h100);
    check_eq("addi_hart", out_hart, 3);
    check_eq("addi_ill", out_illegal, 0);

    // beq x1,x2,-4 back to back with previous entry popping
    send(32'hFE208EE3, 32'h104, 3'd0);
    check_eq("beq_op", out_opcode, 6'h1D);
    check_eq("beq_imm", out_imm, 32'hFFFFFFFC);
    check_eq("beq_rs1", out_rs1, 1);
    check_eq("beq_rs2", out_rs2, 2);
    check_eq("beq_type", out_type, 6'h04);

    send(32'h3002D073, 32'h108, 3'd0);
    check_eq("csrrwi_op", out_opcode, 6'h2A);
    check_eq("csrrwi_csr", out_csr, 12'h300);
    check_eq("csrrwi_imm", out_imm, 5);
    check_eq("csrrwi_rd", out_rd, 0);
    check_eq("csrrwi_rs1", out_rs1, 5);

    send(32'h4030D093, 32'h10C, 3'd0);
    check_eq("srai_op", out_opcode, 6'h0D);
    check_eq("srai_imm", out_imm, 3);
    tick();
    check_eq("drain_valid", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200;
    tick();
    check_eq("bp_ready1", in_ready, 1);
    check_eq("bp_head1", out_pc, 32'h200);
    in_instr = 32'h402081B3; in_pc = 32'h204;
    tick();
    check_eq("bp_ready2", in_ready, 0);
    in_instr = 32'h123450B7; in_pc = 32'h208;
    tick();
    check_eq("bp_ready3", in_ready, 0);
    check_eq("bp_head_pc", out_pc, 32'h200);
    check_eq("bp_head_op", out_opcode, 6'h0E);
    check_eq("bp_head_type", out_type, 6'h20);
    check_eq("bp_head_imm", out_imm, 0);
    out_ready = 1'b1;
    tick();
    check_eq("bp_pop1_pc", out_pc, 32'h204);
    check_eq("bp_pop1_op", out_opcode, 6'h10);
    check_eq("bp_ready4", in_ready, 1);
    tick();
    check_eq("bp_pop2_pc", out_pc, 32'h208);
    check_eq("lui_op", out_opcode, 6'h11);
    check_eq("lui_imm", out_imm, 32'h12345000);
    check_eq("lui_type", out_type, 6'h02);
    in_instr = 32'h008000EF; in_pc = 32'h20C;
    tick();
    check_eq("jal_pc", out_pc, 32'h20C);
    check_eq("jal_op", out_opcode, 6'h23);
    check_eq("jal_imm", out_imm, 8);
    check_eq("jal_type", out_type, 6'h01);
    in_valid = 1'b0;
    tick();
    check_eq("bp_empty", out_valid, 0);

    // illegal / nop / ill_cnt
    send(32'hFFFFFFFF, 32'h300, 3'd0);
    check_eq("unk_op", out_opcode, 6'h3F);
    check_eq("unk_type", out_type, 6'h3F);
    check_eq("unk_ill", out_illegal, 1);
    check_eq("unk_cnt", ill_cnt, 1);
    send(32'h00000000, 32'h304, 3'd0);
    check_eq("nop_op", out_opcode, 6'h32);
    check_eq("nop_type", out_type, 6'h00);
    check_eq("nop_ill", out_illegal, 0);
    check_eq("nop_cnt", ill_cnt, 1);
    send(32'h40009093, 32'h308, 3'd0);
    check_eq("slli_bad_ill", out_illegal, 1);
    check_eq("slli_bad_rd", out_rd, 1);
    check_eq("slli_bad_cnt", ill_cnt, 2);
    tick();

    // flush with full FIFO and a simultaneous illegal input
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00293; in_pc = 32'h400;
    tick(); tick();
    check_eq("fl_full_valid", out_valid, 1);
    check_eq("fl_full_ready", in_ready, 0);
    flush = 1'b1; in_instr = 32'hFFFFFFFF; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_valid", out_valid, 0);
    check_eq("fl_ready", in_ready, 1);
    check_eq("fl_cnt", ill_cnt, 2);
    // flush must also beat an acceptable push
    send(32'hFFF00293, 32'h410, 3'd0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl2_valid", out_valid, 0);
    check_eq("fl2_cnt", ill_cnt, 2);

    // EN_CSR=0 instance, 4-bit counter
    send_b(32'h30029073);
    check_eq("nocsr_ill", b_out_illegal, 1);
    check_eq("nocsr_op", b_out_opcode, 6'h3F);
    check_eq("nocsr_cnt", b_ill_cnt, 1);
    send_b(32'h3002D073);
    check_eq("nocsri_ill", b_out_illegal, 1);
    check_eq("nocsri_rs1", b_out_rs1, 5);
    check_eq("nocsri_cnt", b_ill_cnt, 2);
    b_in_valid = 1'b1; b_in_instr = 32'hFFFFFFFF;
    repeat (12) tick();
    check_eq("sat_pre", b_ill_cnt, 4'hE);
    tick();
    check_eq("sat_hit", b_ill_cnt, 4'hF);
    repeat (4) tick();
    check_eq("sat_hold", b_ill_cnt, 4'hF);

    // reset with entries held
    b_out_ready = 1'b0; b_in_instr = 32'hFFF00293;
    tick(); tick();
    b_in_valid = 1'b0;
    check_eq("hold_valid", b_out_valid, 1);
    check_eq("hold_ready", b_in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rst2_valid", b_out_valid, 0);
    check_eq("rst2_ready", b_in_ready, 1);
    check_eq("rst2_cnt", b_ill_cnt, 0);
    check_eq("rst2_opcode", b_out_opcode, 0);
    check_eq("rst2_main_cnt", ill_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
